spi_bus_monitor: RTL

- Passive, synthesizable SPI bus monitor: samples SCLK, CS_n, PICO and POCI in the system clock domain.
- Reconstructs each full-duplex byte pair and presents it on a valid/ready output.
- Reports frame boundaries and error conditions.
- Sits beside the SPI controller/peripheral pair as the reader for the traffic that the driver writes; used for on-chip logging and bench scoreboarding.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_sync.sv | 26 ++
 rtl/spi_bus_monitor.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI types, mode decoding helpers and constants for the bus monitor.
package spi_pkg;

   typedef enum logic [1:0] {
      SPI_MODE_0 = 2'd0,
      SPI_MODE_1 = 2'd1,
      SPI_MODE_2 = 2'd2,
      SPI_MODE_3 = 2'd3
   } spi_mode_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } mon_state_t;

   localparam int BITS_PER_BYTE = 8;

   function automatic logic cpol(input spi_mode_t mode);
      return mode[1];
   endfunction

   function automatic logic cpha(input spi_mode_t mode);
      return mode[0];
   endfunction

   function automatic logic sample_on_rising(input spi_mode_t mode);
      return cpol(mode) == cpha(mode);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-bit flop-chain synchronizer with a per-bit reset value.
module spi_sync #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/spi_bus_monitor.sv
// Passive SPI monitor: rebuilds full-duplex byte pairs per CS frame and
// presents them on a one-entry valid/ready register with frame/error flags.
module spi_bus_monitor
   import spi_pkg::*;
#(
   parameter int  SPI_MODE         = 0,
   parameter int  MAX_BYTES_PER_CS = 2,
   parameter int  SYNC_STAGES      = 2,
   localparam int IDX_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic             i_SPI_Clk,
   input  logic             i_SPI_CS_n,
   input  logic             i_SPI_PICO,
   input  logic             i_SPI_POCI,
   output logic             o_Byte_DV,
   input  logic             i_Byte_Ready,
   output logic [7:0]       o_PICO_Byte,
   output logic [7:0]       o_POCI_Byte,
   output logic [IDX_W-1:0] o_Byte_Idx,
   output logic             o_Frame_End,
   output logic [IDX_W-1:0] o_Frame_Bytes,
   output logic             o_Frame_Partial,
   output logic             o_Overflow,
   output logic             o_Frame_Overrun
);

   localparam spi_mode_t         MODE      = spi_mode_t'(SPI_MODE[1:0]);
   localparam logic              SCLK_IDLE = cpol(MODE);
   localparam logic              RISE      = sample_on_rising(MODE);
   localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(MAX_BYTES_PER_CS);
   localparam logic [2:0]        LAST_BIT  = 3'(BITS_PER_BYTE - 1);
   localparam int                WARM_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);

   logic [3:0] sync_s;
   logic       sclk_s, csn_s, pico_s, poci_s;

   spi_sync #(
      .WIDTH   (4),
      .DEPTH   (SYNC_STAGES),
      .RST_VAL ({SCLK_IDLE, 1'b1, 2'b00})
   ) u_sync (
      .clk_i (i_Clk),
      .rst_i (i_Rst),
      .d_i   ({i_SPI_Clk, i_SPI_CS_n, i_SPI_PICO, i_SPI_POCI}),
      .q_o   (sync_s)
   );

   assign {sclk_s, csn_s, pico_s, poci_s} = sync_s;

   mon_state_t        state_q;
   logic              sclk_h_q, armed_q;
   logic [WARM_W-1:0] warm_q;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        pico_sh_q, pico_sh_d, poci_sh_q, poci_sh_d;
   logic              sample_edge, sample_act, byte_done;
   logic              byte_done_q, fe_q, fe_partial_q;
   logic [7:0]        done_pico_q, done_poci_q;
   logic [IDX_W-1:0]  done_idx_q, fe_bytes_q;

   always_comb begin
      sample_edge = RISE ? (sclk_s & ~sclk_h_q) : (~sclk_s & sclk_h_q);
      sample_act  = (state_q == ST_ACTIVE) && sample_edge;
      pico_sh_d   = {pico_sh_q[6:0], pico_s};
      poci_sh_d   = {poci_sh_q[6:0], poci_s};
      bit_cnt_d   = sample_act ? bit_cnt_q + 3'd1 : bit_cnt_q;
      byte_done   = sample_act && (bit_cnt_q == LAST_BIT);
      idx_d       = (byte_done && (idx_q != IDX_MAX)) ? idx_q + 1'b1 : idx_q;
   end

   // Capture stage: armed_q blocks joining a frame whose CS fell before reset release.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q      <= ST_IDLE;
         sclk_h_q     <= SCLK_IDLE;
         armed_q      <= 1'b0;
         warm_q       <= '0;
         bit_cnt_q    <= '0;
         idx_q        <= '0;
         pico_sh_q    <= '0;
         poci_sh_q    <= '0;
         byte_done_q  <= 1'b0;
         done_pico_q  <= '0;
         done_poci_q  <= '0;
         done_idx_q   <= '0;
         fe_q         <= 1'b0;
         fe_bytes_q   <= '0;
         fe_partial_q <= 1'b0;
      end else begin
         sclk_h_q    <= sclk_s;
         byte_done_q <= 1'b0;
         fe_q        <= 1'b0;
         if (warm_q != WARM_DONE) warm_q <= warm_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (armed_q && !csn_s) begin
                  state_q   <= ST_ACTIVE;
                  bit_cnt_q <= '0;
                  idx_q     <= '0;
                  pico_sh_q <= '0;
                  poci_sh_q <= '0;
               end else if (csn_s && (warm_q == WARM_DONE)) begin
                  armed_q <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (sample_edge) begin
                  pico_sh_q <= pico_sh_d;
                  poci_sh_q <= poci_sh_d;
                  bit_cnt_q <= bit_cnt_d;
                  idx_q     <= idx_d;
               end
               if (byte_done) begin
                  byte_done_q <= 1'b1;
                  done_pico_q <= pico_sh_d;
                  done_poci_q <= poci_sh_d;
                  done_idx_q  <= idx_q;
               end
               if (csn_s) begin
                  state_q      <= ST_IDLE;
                  fe_q         <= 1'b1;
                  fe_bytes_q   <= idx_d;
                  fe_partial_q <= (bit_cnt_d != 3'd0);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   logic             dv_q, fe_out_q, partial_q, ovf_q, ovr_q;
   logic [7:0]       pico_q, poci_q;
   logic [IDX_W-1:0] idx_out_q, frame_bytes_q;

   // Output stage: a completion during an accept replaces the entry without a bubble.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         dv_q          <= 1'b0;
         pico_q        <= '0;
         poci_q        <= '0;
         idx_out_q     <= '0;
         fe_out_q      <= 1'b0;
         frame_bytes_q <= '0;
         partial_q     <= 1'b0;
         ovf_q         <= 1'b0;
         ovr_q         <= 1'b0;
      end else begin
         fe_out_q <= fe_q;
         if (fe_q) begin
            frame_bytes_q <= fe_bytes_q;
            partial_q     <= fe_partial_q;
         end
         if (byte_done_q) begin
            if (done_idx_q == IDX_MAX) ovr_q <= 1'b1;
            if (!dv_q || i_Byte_Ready) begin
               dv_q      <= 1'b1;
               pico_q    <= done_pico_q;
               poci_q    <= done_poci_q;
               idx_out_q <= done_idx_q;
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (i_Byte_Ready) begin
            dv_q <= 1'b0;
         end
      end
   end

   assign o_Byte_DV       = dv_q;
   assign o_PICO_Byte     = pico_q;
   assign o_POCI_Byte     = poci_q;
   assign o_Byte_Idx      = idx_out_q;
   assign o_Frame_End     = fe_out_q;
   assign o_Frame_Bytes   = frame_bytes_q;
   assign o_Frame_Partial = partial_q;
   assign o_Overflow      = ovf_q;
   assign o_Frame_Overrun = ovr_q;

endmodule
